// File: rtl/rv_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus the
// {pc, inst} hand-off to decode. The fetch unit uses the master modport.
interface rv_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  if_valid;
  logic                  if_ready;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [DATA_WIDTH-1:0] if_inst;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output if_valid,
    output if_pc,
    output if_inst,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  if_valid,
    input  if_pc,
    input  if_inst,
    output if_ready
  );
endinterface

// File: rtl/rv_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues imem reads, buffers in-order
// responses and presents {pc, inst} to decode. Option: RV_FETCH_MISALIGN_CHK_EN.
module rv_fetch_unit #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'h0000_0000,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_fault,
  rv_fetch_unit_if.master       bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SUM_W = CNT_W + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and the response channel has no ready
  // (exactly one imem_rsp_valid pulse per accepted request, in request order).

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CNT_W-1:0]      out_cnt_q;
  logic [CNT_W-1:0]      drop_cnt_q;
  logic [CNT_W-1:0]      fifo_cnt_q;
  logic [PTR_W-1:0]      aq_wr_q;
  logic [PTR_W-1:0]      aq_rd_q;
  logic [PTR_W-1:0]      fifo_wr_q;
  logic [PTR_W-1:0]      fifo_rd_q;
  logic [ADDR_WIDTH-1:0] last_pc_q;
  logic [DATA_WIDTH-1:0] last_inst_q;
  logic                  fault_q;

  logic [ADDR_WIDTH-1:0] aq_mem     [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] fifo_pc    [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0] fifo_inst  [MAX_OUTSTANDING];

  logic                  req_fire;
  logic                  rsp_keep;
  logic                  fifo_pop;
  logic                  fifo_nonempty;
  logic [SUM_W-1:0]      inflight_sum;
  logic                  can_issue;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  misaligned_redirect;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef RV_FETCH_MISALIGN_CHK_EN
  assign redirect_target     = redirect_pc;
  assign misaligned_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (misaligned_redirect) begin
      fault_q <= 1'b1;
    end
  end
`else
  // Misaligned targets are silently aligned down; no fault is ever raised.
  assign redirect_target     = redirect_pc & ~ADDR_WIDTH'(3);
  assign misaligned_redirect = 1'b0;
  assign fault_q             = 1'b0;
`endif

  assign fetch_fault = fault_q;

  // Dropped and buffered entries both occupy a slot, so a response can never
  // find the output FIFO full.
  assign inflight_sum = SUM_W'(out_cnt_q) + SUM_W'(fifo_cnt_q);
  assign can_issue    = inflight_sum < SUM_W'(MAX_OUTSTANDING);

  assign bus.imem_req_valid = !rst && !redirect_valid && !fault_q && can_issue;
  assign bus.imem_req_addr  = pc_q;

  assign req_fire      = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep      = bus.imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign fifo_pop      = fifo_nonempty && bus.if_ready && !redirect_valid;

  assign bus.if_valid = fifo_nonempty;
  assign bus.if_pc    = fifo_nonempty ? fifo_pc[fifo_rd_q]   : last_pc_q;
  assign bus.if_inst  = fifo_nonempty ? fifo_inst[fifo_rd_q] : last_inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      out_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      fifo_cnt_q  <= '0;
      aq_wr_q     <= '0;
      aq_rd_q     <= '0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      last_pc_q   <= '0;
      last_inst_q <= '0;
    end else begin
      case ({req_fire, bus.imem_rsp_valid})
        2'b10:   out_cnt_q <= out_cnt_q + CNT_W'(1);
        2'b01:   out_cnt_q <= out_cnt_q - CNT_W'(1);
        default: out_cnt_q <= out_cnt_q;
      endcase

      // Empty output keeps showing the last presented pair.
      if (fifo_nonempty) begin
        last_pc_q   <= fifo_pc[fifo_rd_q];
        last_inst_q <= fifo_inst[fifo_rd_q];
      end

      if (redirect_valid) begin
        pc_q       <= redirect_target;
        aq_wr_q    <= '0;
        aq_rd_q    <= '0;
        fifo_wr_q  <= '0;
        fifo_rd_q  <= '0;
        fifo_cnt_q <= '0;
        drop_cnt_q <= out_cnt_q - CNT_W'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) begin
          pc_q    <= pc_q + ADDR_WIDTH'(4);
          aq_wr_q <= ptr_inc(aq_wr_q);
        end

        if (bus.imem_rsp_valid && (drop_cnt_q != '0)) begin
          drop_cnt_q <= drop_cnt_q - CNT_W'(1);
        end

        if (rsp_keep) begin
          aq_rd_q   <= ptr_inc(aq_rd_q);
          fifo_wr_q <= ptr_inc(fifo_wr_q);
        end

        if (fifo_pop) begin
          fifo_rd_q <= ptr_inc(fifo_rd_q);
        end

        case ({rsp_keep, fifo_pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
          2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
      end
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      aq_mem[aq_wr_q] <= pc_q;
    end
    if (rsp_keep) begin
      fifo_pc[fifo_wr_q]   <= aq_mem[aq_rd_q];
      fifo_inst[fifo_wr_q] <= bus.imem_rsp_data;
    end
  end

endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
- Consumer end of the next-PC path: owns the architectural fetch PC.
- Issues instruction-memory read requests and buffers the in-order responses.
- Hands {pc, inst} pairs to decode over a valid/ready handshake.
- Accepts redirects (br_taken / target from EX), flushing buffered and in-flight fetches.

Parameters:
- ADDR_WIDTH, 32, PC / memory address width.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_OUTSTANDING, 2, combined limit on in-flight requests plus buffered entries.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  taken branch/jump from EX (br_taken).
- redirect_pc  input  ADDR_WIDTH  redirect target (nextpc).
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  ADDR_WIDTH  fetch address.
- imem_rsp_valid  input  1  response valid; exactly one per accepted request, in order, no backpressure.
- imem_rsp_data  input  DATA_WIDTH  fetched instruction.
- if_valid  output  1  instruction available to decode.
- if_ready  input  1  decode accepts.
- if_pc  output  ADDR_WIDTH  PC of presented instruction.
- if_inst  output  DATA_WIDTH  presented instruction.
- fetch_fault  output  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset (sync, rst=1 at clock edge):
  - pc_q=RESET_PC.
  - Outstanding count, drop count, address queue and output FIFO all cleared.
  - imem_req_valid=0, if_valid=0, if_pc=0, if_inst=0, fetch_fault=0.
  - rst mid-operation discards everything; responses arriving afterwards for pre-reset requests are ignored via drop count = 0 and out-of-order tolerance is NOT required (memory is reset together).
- Request issue:
  - imem_req_valid=1 when !rst, !redirect_valid, !fetch_fault, and (outstanding + fifo_count) < MAX_OUTSTANDING.
  - imem_req_addr=pc_q.
  - On accept (valid&&ready): pc_q <= pc_q+4, wrapping modulo 2^ADDR_WIDTH.
  - On accept: pc_q pushed to a MAX_OUTSTANDING-deep address queue; outstanding++.
- Response:
  - On imem_rsp_valid: outstanding--.
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Else: {addr_queue head, imem_rsp_data} pushed to output FIFO and the addr queue is popped.
- Output: if_valid = FIFO non-empty; FIFO head drives if_pc/if_inst. Pop on if_valid&&if_ready.
- Latency: request accepted in cycle N, response in N+1 at earliest, if_valid in N+2.
- Redirect (redirect_valid=1):
  - pc_q <= redirect_pc.
  - Output FIFO and address queue cleared; if_valid=0 next cycle.
  - drop_cnt <= outstanding minus any response arriving this cycle.
  - No request issued in the redirect cycle.
  - A same-cycle response is discarded.
  - A same-cycle if_ready pop is irrelevant (FIFO cleared).
- Full: no issue while outstanding+fifo_count=MAX_OUTSTANDING. Decode stall (if_ready=0) therefore throttles requests; no response can ever overflow the FIFO.
- Empty: if_valid=0; if_pc/if_inst hold last values.
- Simultaneous push and pop on the FIFO in the same cycle is allowed; count is unchanged.

Optional Feature:
- Macro RV_FETCH_MISALIGN_CHK_EN.
- Defined:
  - redirect_valid with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until rst).
  - pc_q is loaded with redirect_pc unmodified and all fetching stops (imem_req_valid=0).
  - The flush still occurs.
- Undefined: redirect_pc[1:0] is forced to 2'b00 on load; fetch_fault is tied 0.

Test Plan:
- Reset then imem_req_ready=1, 1-cycle memory, if_ready=1 -> requests at 0x0,0x4,0x8...; if_pc sequence 0x0,0x4,0x8 with the first if_valid two cycles after the first accept.
- if_ready=0 for 10 cycles -> at most 2 requests accepted, FIFO holds 0x0/0x4; release -> in-order delivery, no loss or duplicate.
- 2 requests in flight, redirect_pc=0x100 -> both responses dropped; next if_pc=0x100, then 0x104.
- Redirect in the same cycle as a response and if_ready=1 -> response discarded, no request that cycle, next request addr=0x100.
- pc_q=0xFFFF_FFFC fetch -> next request addr 0x0000_0000 (wrap).
- Redirect to 0x102: macro defined -> fetch_fault=1, imem_req_valid stays 0; macro undefined -> next request addr 0x100, fetch_fault=0.
